// File: rtl/parallel_data_pack.sv
// parallel_data_pack: gathers LANE_WIDTH-bit samples into LANES-lane words, first sample in the LSBs.
// Optional feature macro PACK_FLUSH_EN adds s_last/m_lanes for early, zero-padded word emission.
module parallel_data_pack #(
  parameter int LANE_WIDTH = 16,
  parameter int LANES      = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [LANE_WIDTH-1:0]       s_data,
`ifdef PACK_FLUSH_EN
  input  logic                        s_last,
  output logic [$clog2(LANES):0]      m_lanes,
`endif
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [LANE_WIDTH*LANES-1:0] m_data,
  output logic [$clog2(LANES)-1:0]    lane_idx
);
  localparam int W     = LANE_WIDTH * LANES;
  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  // Writes one sample into lane idx; optionally clears every lane above it.
  function automatic logic [W-1:0] insert_lane(input logic [W-1:0]          word,
                                               input logic [IDX_W-1:0]      idx,
                                               input logic [LANE_WIDTH-1:0] sample,
                                               input logic                  zero_upper);
    logic [W-1:0] res;
    res = word;
    for (int i = 0; i < LANES; i++) begin
      if (i == int'(idx))
        res[i*LANE_WIDTH +: LANE_WIDTH] = sample;
      else if (zero_upper && (i > int'(idx)))
        res[i*LANE_WIDTH +: LANE_WIDTH] = '0;
    end
    return res;
  endfunction

  logic                   rdy_p0;
  logic [IDX_W-1:0]       idx_p0;
  logic [W-1:0]           buf_p0;
  logic                   vld_p1;
  logic [W-1:0]           data_p1;
  logic                   flush_req;
  logic                   complete_lane;
  logic                   accept;
  logic [W-1:0]           word_next;

`ifdef PACK_FLUSH_EN
  assign flush_req = s_last;
`else
  assign flush_req = 1'b0;
`endif

  // A completing accept needs the output slot, so only that lane can stall.
  assign complete_lane = (idx_p0 == LAST_IDX) | flush_req;
  assign s_ready       = rdy_p0 & ~(complete_lane & vld_p1 & ~m_ready);
  assign accept        = s_valid & s_ready;
  assign word_next     = insert_lane(buf_p0, idx_p0, s_data, flush_req);

  // Stage p0: assembly buffer and lane pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      rdy_p0 <= 1'b0;
      idx_p0 <= '0;
      buf_p0 <= '0;
    end else begin
      rdy_p0 <= 1'b1;
      if (accept) begin
        buf_p0 <= insert_lane(buf_p0, idx_p0, s_data, 1'b0);
        idx_p0 <= complete_lane ? '0 : idx_p0 + 1'b1;
      end
    end
  end

  // Stage p1: output word register, held while downstream stalls
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (accept && complete_lane) begin
      vld_p1  <= 1'b1;
      data_p1 <= word_next;
    end else if (m_ready) begin
      vld_p1  <= 1'b0;
    end
  end

`ifdef PACK_FLUSH_EN
  logic [IDX_W:0] lanes_p1;

  always_ff @(posedge clock) begin
    if (reset)
      lanes_p1 <= '0;
    else if (accept && complete_lane)
      lanes_p1 <= {1'b0, idx_p0} + 1'b1;
  end

  assign m_lanes = lanes_p1;
`endif

  assign m_valid  = vld_p1;
  assign m_data   = data_p1;
  assign lane_idx = idx_p0;

endmodule
